// File: rtl/level_defs_pkg.sv
// Shared definitions for the level-advance controller: FSM encoding and default limits.
package level_defs_pkg;

    typedef enum logic [2:0] {
        ST_COUNT = 3'd0,
        ST_LOAD  = 3'd1,
        ST_WAIT  = 3'd2,
        ST_MAXED = 3'd3,
        ST_CLEAR = 3'd4
    } lvl_state_t;

    localparam int unsigned MAX_LEVEL_DEF = 3;
    localparam int unsigned TICK_BASE_DEF = 1024;

endpackage

// File: rtl/level_tick_div.sv
// Speed-tick divider: one-cycle tick every (TICK_BASE >> level) clocks, restarted on level change or clear.
module level_tick_div #(
    parameter int unsigned DATAWIDTH = 2,
    parameter int unsigned TICK_BASE = 1024
) (
    input  logic                 SC_RegNIVEL_CLOCK_50,
    input  logic                 SC_RegNIVEL_RESET_InHigh,
    input  logic                 restart_i,
    input  logic [DATAWIDTH-1:0] level_i,
    output logic                 tick_o
);

    localparam int unsigned DW = $clog2(TICK_BASE + 1);

    logic [DW-1:0]        div_q, div_d;
    logic [DATAWIDTH-1:0] lvl_q;
    logic                 tick_q, tick_d;
    int unsigned          period;

    always_comb begin
        period = TICK_BASE >> level_i;
        // Deep levels can shift the period to zero; clamp so the tick stays defined.
        if (period == 0) begin
            period = 1;
        end
        tick_d = 1'b0;
        div_d  = div_q + 1'b1;
        if (restart_i || (level_i != lvl_q)) begin
            div_d = '0;
        end else if (div_q == DW'(period - 1)) begin
            div_d  = '0;
            tick_d = 1'b1;
        end
    end

    always_ff @(posedge SC_RegNIVEL_CLOCK_50 or posedge SC_RegNIVEL_RESET_InHigh) begin
        if (SC_RegNIVEL_RESET_InHigh) begin
            div_q  <= '0;
            lvl_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            lvl_q  <= level_i;
            tick_q <= tick_d;
        end
    end

    assign tick_o = tick_q;

endmodule

// File: rtl/level_advance_ctrl.sv
// Level-advance controller: counts score points and strobes the external level register.
// Optional speed tick enabled with macro LEVEL_SPEED_TICK_EN.
module level_advance_ctrl
    import level_defs_pkg::*;
#(
    parameter int unsigned DATAWIDTH        = 2,
    parameter int unsigned POINTS_PER_LEVEL = 8,
    parameter int unsigned MAX_LEVEL        = MAX_LEVEL_DEF,
    parameter int unsigned TICK_BASE        = TICK_BASE_DEF
) (
    input  logic                 SC_RegNIVEL_CLOCK_50,
    input  logic                 SC_RegNIVEL_RESET_InHigh,
    input  logic                 point_In,
    input  logic                 restart_InLow,
    input  logic [DATAWIDTH-1:0] level_InBUS,
    output logic                 load_OutLow,
    output logic                 clear_OutLow,
    output logic [DATAWIDTH-1:0] level_OutBUS,
    output logic                 levelup_Out,
    output logic                 tick_Out,
    output lvl_state_t           state_dbg,
    output logic [7:0]           point_cnt_dbg
);

    localparam int unsigned          CW       = $clog2(POINTS_PER_LEVEL);
    localparam logic [CW-1:0]        CNT_LAST = CW'(POINTS_PER_LEVEL - 1);
    localparam logic [DATAWIDTH-1:0] LVL_MAX  = DATAWIDTH'(MAX_LEVEL);

    lvl_state_t           state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [DATAWIDTH-1:0] lvl_out_q, lvl_out_d;
    logic                 point_q;
    logic                 load_n_q, load_n_d;
    logic                 clear_n_q, clear_n_d;
    logic                 levelup_q, levelup_d;
    logic                 point_rise;

    assign point_rise = point_In & ~point_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        lvl_out_d = lvl_out_q;
        if (!restart_InLow) begin
            state_d   = ST_CLEAR;
            cnt_d     = '0;
            lvl_out_d = '0;
        end else begin
            case (state_q)
                ST_COUNT: begin
                    if (point_rise) begin
                        if (cnt_q == CNT_LAST) begin
                            cnt_d = '0;
                            if (level_InBUS < LVL_MAX) begin
                                state_d   = ST_LOAD;
                                lvl_out_d = level_InBUS + 1'b1;
                            end else begin
                                state_d = ST_MAXED;
                            end
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    state_d = ST_WAIT;
                    if (point_rise && (cnt_q != CNT_LAST)) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                // The level register has taken the new value by now, so check it for saturation.
                ST_WAIT: begin
                    if (level_InBUS >= LVL_MAX) begin
                        state_d = ST_MAXED;
                        cnt_d   = '0;
                    end else begin
                        state_d = ST_COUNT;
                        if (point_rise && (cnt_q != CNT_LAST)) begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                ST_MAXED: begin
                    cnt_d = '0;
                end
                ST_CLEAR: begin
                    state_d   = ST_COUNT;
                    cnt_d     = '0;
                    lvl_out_d = '0;
                end
                default: begin
                    state_d = ST_COUNT;
                    cnt_d   = '0;
                end
            endcase
        end
        load_n_d  = (state_d != ST_LOAD);
        levelup_d = (state_d == ST_LOAD);
        clear_n_d = (state_d != ST_CLEAR);
    end

    always_ff @(posedge SC_RegNIVEL_CLOCK_50 or posedge SC_RegNIVEL_RESET_InHigh) begin
        if (SC_RegNIVEL_RESET_InHigh) begin
            state_q   <= ST_COUNT;
            cnt_q     <= '0;
            lvl_out_q <= '0;
            point_q   <= 1'b0;
            load_n_q  <= 1'b1;
            clear_n_q <= 1'b1;
            levelup_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            lvl_out_q <= lvl_out_d;
            point_q   <= point_In;
            load_n_q  <= load_n_d;
            clear_n_q <= clear_n_d;
            levelup_q <= levelup_d;
        end
    end

    assign load_OutLow   = load_n_q;
    assign clear_OutLow  = clear_n_q;
    assign level_OutBUS  = lvl_out_q;
    assign levelup_Out   = levelup_q;
    assign state_dbg     = state_q;
    assign point_cnt_dbg = 8'(cnt_q);

`ifdef LEVEL_SPEED_TICK_EN
    level_tick_div #(
        .DATAWIDTH (DATAWIDTH),
        .TICK_BASE (TICK_BASE)
    ) u_tick_div (
        .SC_RegNIVEL_CLOCK_50     (SC_RegNIVEL_CLOCK_50),
        .SC_RegNIVEL_RESET_InHigh (SC_RegNIVEL_RESET_InHigh),
        .restart_i                (~clear_n_q),
        .level_i                  (level_InBUS),
        .tick_o                   (tick_Out)
    );
`else
    assign tick_Out = 1'b0;
`endif

endmodule

// File: tb/tb_level_advance_ctrl.sv
// Bench for level_advance_ctrl: vector table, corner sequences and a randomized run against a point/level model.
module tb_level_advance_ctrl;
    import level_defs_pkg::*;

    localparam int PPL = 4;
    localparam int MAXL = 3;
    localparam int TB_TICK = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       point_In = 1'b0;
    logic       restart_InLow = 1'b1;
    logic [1:0] level_InBUS = 2'd0;
    logic       load_OutLow, clear_OutLow, levelup_Out, tick_Out;
    logic [1:0] level_OutBUS;
    lvl_state_t state_dbg;
    logic [7:0] point_cnt_dbg;

    int  n_checks = 0;
    int  n_fail = 0;
    bit  track_lvl = 1'b0;

    // model of points and level progress
    int  m_pts, m_busy, m_lvl_out;
    bit  m_maxed, m_clearing, m_prev;

    typedef struct {
        logic       p;
        logic       r;
        logic [1:0] lvl;
        logic       ld_n;
        logic       cl_n;
        logic       up;
        logic [1:0] out;
        int         cnt;
    } vec_t;
    vec_t vecs[11];

    level_advance_ctrl #(
        .DATAWIDTH        (2),
        .POINTS_PER_LEVEL (PPL),
        .MAX_LEVEL        (MAXL),
        .TICK_BASE        (TB_TICK)
    ) dut (
        .SC_RegNIVEL_CLOCK_50     (clk),
        .SC_RegNIVEL_RESET_InHigh (rst),
        .point_In                 (point_In),
        .restart_InLow            (restart_InLow),
        .level_InBUS              (level_InBUS),
        .load_OutLow              (load_OutLow),
        .clear_OutLow             (clear_OutLow),
        .level_OutBUS             (level_OutBUS),
        .levelup_Out              (levelup_Out),
        .tick_Out                 (tick_Out),
        .state_dbg                (state_dbg),
        .point_cnt_dbg            (point_cnt_dbg)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pts = 0; m_busy = 0; m_lvl_out = 0;
        m_maxed = 0; m_clearing = 0; m_prev = 0;
    endtask

    task automatic model_cycle(input bit p, input bit r, input int lvl);
        bit rise;
        rise = p && !m_prev;
        m_prev = p;
        if (!r) begin
            m_clearing = 1; m_pts = 0; m_lvl_out = 0; m_maxed = 0; m_busy = 0;
        end else if (m_clearing) begin
            m_clearing = 0; m_pts = 0;
        end else if (m_maxed) begin
            m_pts = 0;
        end else if (m_busy == 1) begin
            m_busy = 2;
            if (rise) m_pts++;
        end else if (m_busy == 2) begin
            m_busy = 0;
            if (lvl >= MAXL) begin
                m_maxed = 1; m_pts = 0;
            end else if (rise) begin
                m_pts++;
            end
        end else if (rise) begin
            if (m_pts == PPL - 1) begin
                m_pts = 0;
                if (lvl < MAXL) begin
                    m_busy = 1; m_lvl_out = lvl + 1;
                end else begin
                    m_maxed = 1;
                end
            end else begin
                m_pts++;
            end
        end
    endtask

    // One clock: apply inputs, advance the model, update the external level register.
    task automatic step(input logic p, input logic r);
        logic       ld_n, cl_n;
        logic [1:0] lo;
        point_In = p;
        restart_InLow = r;
        model_cycle(p, r, int'(level_InBUS));
        ld_n = load_OutLow;
        cl_n = clear_OutLow;
        lo = level_OutBUS;
        @(posedge clk);
        #1;
        if (track_lvl) begin
            if (!cl_n) level_InBUS = 2'd0;
            else if (!ld_n) level_InBUS = lo;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        point_In = 1'b0;
        restart_InLow = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic pulses(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b1, 1'b1);
            step(1'b0, 1'b1);
        end
    endtask

    task automatic restart_seq();
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
    endtask

    initial begin
        int  any_load, found, period;
        vecs[0]  = '{1'b1, 1'b1, 2'd0, 1'b1, 1'b1, 1'b0, 2'd0, 1};
        vecs[1]  = '{1'b0, 1'b1, 2'd0, 1'b1, 1'b1, 1'b0, 2'd0, 1};
        vecs[2]  = '{1'b1, 1'b1, 2'd0, 1'b1, 1'b1, 1'b0, 2'd0, 2};
        vecs[3]  = '{1'b0, 1'b1, 2'd0, 1'b1, 1'b1, 1'b0, 2'd0, 2};
        vecs[4]  = '{1'b1, 1'b1, 2'd0, 1'b1, 1'b1, 1'b0, 2'd0, 3};
        vecs[5]  = '{1'b0, 1'b1, 2'd0, 1'b1, 1'b1, 1'b0, 2'd0, 3};
        vecs[6]  = '{1'b1, 1'b1, 2'd0, 1'b0, 1'b1, 1'b1, 2'd1, 0};
        vecs[7]  = '{1'b0, 1'b1, 2'd1, 1'b1, 1'b1, 1'b0, 2'd1, 0};
        vecs[8]  = '{1'b0, 1'b1, 2'd1, 1'b1, 1'b1, 1'b0, 2'd1, 0};
        vecs[9]  = '{1'b1, 1'b0, 2'd1, 1'b1, 1'b0, 1'b0, 2'd0, 0};
        vecs[10] = '{1'b0, 1'b1, 2'd1, 1'b1, 1'b1, 1'b0, 2'd0, 0};

        // Reset values
        rst = 1'b1;
        #12;
        check("rst_load_n", int'(load_OutLow), 1);
        check("rst_clear_n", int'(clear_OutLow), 1);
        check("rst_level_out", int'(level_OutBUS), 0);
        check("rst_levelup", int'(levelup_Out), 0);
        check("rst_tick", int'(tick_Out), 0);
        check("rst_state", int'(state_dbg), 0);
        check("rst_cnt", int'(point_cnt_dbg), 0);
        do_reset();

        // Vector table: four points to a level-up, then a restart
        track_lvl = 1'b0;
        for (int i = 0; i < 11; i++) begin
            level_InBUS = vecs[i].lvl;
            step(vecs[i].p, vecs[i].r);
            check($sformatf("vec%0d_load_n", i), int'(load_OutLow), int'(vecs[i].ld_n));
            check($sformatf("vec%0d_clear_n", i), int'(clear_OutLow), int'(vecs[i].cl_n));
            check($sformatf("vec%0d_levelup", i), int'(levelup_Out), int'(vecs[i].up));
            check($sformatf("vec%0d_level_out", i), int'(level_OutBUS), int'(vecs[i].out));
            check($sformatf("vec%0d_cnt", i), int'(point_cnt_dbg), vecs[i].cnt);
        end

        // Held-high point counts once
        level_InBUS = 2'd0;
        restart_seq();
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        check("held_point_cnt", int'(point_cnt_dbg), 1);

        // Max level: no load, MAXED, further points ignored
        restart_seq();
        level_InBUS = 2'd3;
        any_load = 0;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1); if (!load_OutLow) any_load++;
            step(1'b0, 1'b1); if (!load_OutLow) any_load++;
        end
        check("max_no_load", any_load, 0);
        check("max_state", int'(state_dbg), int'(ST_MAXED));
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b1); if (!load_OutLow) any_load++;
            step(1'b0, 1'b1); if (!load_OutLow) any_load++;
        end
        check("max_more_no_load", any_load, 0);
        check("max_more_state", int'(state_dbg), int'(ST_MAXED));
        check("max_more_cnt", int'(point_cnt_dbg), 0);

        // Restart together with the 4th point
        level_InBUS = 2'd0;
        restart_seq();
        pulses(3);
        step(1'b1, 1'b0);
        check("rs4_clear_n", int'(clear_OutLow), 0);
        check("rs4_load_n", int'(load_OutLow), 1);
        check("rs4_cnt", int'(point_cnt_dbg), 0);
        step(1'b0, 1'b1);
        check("rs4_after_clear_n", int'(clear_OutLow), 1);
        check("rs4_after_load_n", int'(load_OutLow), 1);

        // Point right behind a level-up is kept
        restart_seq();
        pulses(3);
        step(1'b1, 1'b1);
        check("lw_load_n", int'(load_OutLow), 0);
        step(1'b0, 1'b1);
        check("lw_wait_load_n", int'(load_OutLow), 1);
        step(1'b1, 1'b1);
        check("lw_cnt", int'(point_cnt_dbg), 1);
        check("lw_state", int'(state_dbg), int'(ST_COUNT));

        // Reset in the middle of LOAD aborts the strobe at once
        restart_seq();
        pulses(3);
        step(1'b1, 1'b1);
        check("rl_in_load", int'(load_OutLow), 0);
        #2 rst = 1'b1;
        #1;
        check("rl_load_n_async", int'(load_OutLow), 1);
        check("rl_levelup_async", int'(levelup_Out), 0);
        do_reset();
        any_load = 0;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1);
            if (!load_OutLow) any_load++;
        end
        check("rl_no_partial_load", any_load, 0);

`ifdef LEVEL_SPEED_TICK_EN
        // Speed tick period at level 0 and level 2
        for (int lv = 0; lv <= 2; lv += 2) begin
            level_InBUS = 2'(lv);
            found = 0;
            for (int i = 0; i < 200 && !found; i++) begin
                step(1'b0, 1'b1);
                if (tick_Out) found = 1;
            end
            check($sformatf("tick_first_lv%0d", lv), found, 1);
            found = 0;
            period = 0;
            for (int i = 0; i < 200 && !found; i++) begin
                step(1'b0, 1'b1);
                period++;
                if (tick_Out) found = 1;
            end
            check($sformatf("tick_period_lv%0d", lv), found ? period : -1, TB_TICK >> lv);
        end
`endif

        // Randomized run against the model, level register closed around the DUT
        do_reset();
        level_InBUS = 2'd0;
        track_lvl = 1'b1;
        for (int i = 0; i < 500; i++) begin
            step(1'($urandom_range(0, 1)), ($urandom_range(0, 15) != 0));
            check("rnd_load_n", int'(load_OutLow), (m_busy == 1) ? 0 : 1);
            check("rnd_levelup", int'(levelup_Out), (m_busy == 1) ? 1 : 0);
            check("rnd_clear_n", int'(clear_OutLow), m_clearing ? 0 : 1);
            check("rnd_level_out", int'(level_OutBUS), m_lvl_out);
            check("rnd_cnt", int'(point_cnt_dbg), m_pts);
`ifndef LEVEL_SPEED_TICK_EN
            check("rnd_tick_off", int'(tick_Out), 0);
`endif
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/level_advance_ctrl.md
LEVEL_ADVANCE_CTRL -- requirements
Module: level_advance_ctrl

Interface
REQ-001 Parameter DATAWIDTH, default 2: level bus width, matched to the level register width.
REQ-002 Parameter POINTS_PER_LEVEL, default 8: points needed per level-up, legal range 2..255.
REQ-003 Parameter MAX_LEVEL, default 2'b11: highest level, saturating.
REQ-004 Parameter TICK_BASE, default 1024: speed-tick period at level 0, in clocks.
REQ-005 SC_RegNIVEL_CLOCK_50  in  1: system clock; all logic on rising edge.
REQ-006 SC_RegNIVEL_RESET_InHigh  in  1: reset, asynchronous, active-high.
REQ-007 point_In  in  1: score event, level-sensitive; each rising edge counts as one point.
REQ-008 restart_InLow  in  1: game restart request, active-low.
REQ-009 level_InBUS  in  DATAWIDTH: current level, read back from the level register output.
REQ-010 load_OutLow  out  1: load strobe to the level register, active-low.
REQ-011 clear_OutLow  out  1: clear strobe to the level register, active-low.
REQ-012 level_OutBUS  out  DATAWIDTH: next-level data to the level register data input.
REQ-013 levelup_Out  out  1: one-cycle pulse on each level-up.
REQ-014 tick_Out  out  1: one-cycle speed tick, level-dependent.

Function
REQ-015 The module SHALL detect the point_In rising edge with one register stage, giving one point per low-to-high transition.
REQ-016 The FSM SHALL have the states COUNT, LOAD, WAIT, MAXED and CLEAR.
REQ-017 In COUNT, each point SHALL increment the point counter, which is sized ceil(log2(POINTS_PER_LEVEL)) bits.
REQ-018 COUNT SHALL go to LOAD when a point arrives with counter == POINTS_PER_LEVEL-1 and level_InBUS < MAX_LEVEL.
  - Counter SHALL clear to 0 on that transition.
REQ-019 COUNT SHALL go to MAXED when a point arrives with counter == POINTS_PER_LEVEL-1 and level_InBUS == MAX_LEVEL.
REQ-020 On the LOAD transition, level_OutBUS SHALL latch level_InBUS+1.
REQ-021 In LOAD, load_OutLow=0 and levelup_Out=1, for exactly one cycle; the FSM then goes to WAIT.
REQ-022 WAIT SHALL last one cycle, then go to COUNT.
  - If level_InBUS then equals MAX_LEVEL, WAIT SHALL go to MAXED instead.
REQ-023 Points arriving in LOAD or WAIT SHALL be counted, not lost.
REQ-024 In MAXED, points SHALL be ignored, the counter SHALL hold at 0, and no load SHALL be issued.
REQ-025 restart_InLow=0 SHALL override every state and any simultaneous point.
  - The next cycle SHALL be CLEAR: clear_OutLow=0 for one cycle, counter=0, level_OutBUS=0.
  - CLEAR SHALL then go to COUNT.
REQ-026 If restart_InLow is held low, the FSM SHALL stay in CLEAR with clear_OutLow=0.
REQ-027 load_OutLow and clear_OutLow SHALL never be 0 in the same cycle.
REQ-028 All outputs SHALL be registered; there SHALL be no combinational path from input to output.

Reset
REQ-029 Asynchronous reset SHALL force:
  - state=COUNT, counter=0, edge register=0;
  - load_OutLow=1, clear_OutLow=1, level_OutBUS=0, levelup_Out=0, tick_Out=0, tick divider=0.
REQ-030 Reset asserted mid-LOAD SHALL abort the strobe immediately, with no partial load pulse after release.

Configuration
REQ-031 Macro LEVEL_SPEED_TICK_EN defined: tick_Out SHALL pulse once every (TICK_BASE >> level_InBUS) clocks.
  - The divider SHALL restart from 0 on any level change or CLEAR.
REQ-032 Macro undefined: the divider logic SHALL be absent and tick_Out SHALL be tied to 0.

Structure
REQ-033 The state encodings (COUNT=0, LOAD=1, WAIT=2, MAXED=3, CLEAR=4, 3-bit) SHALL be defined in the shared package level_defs_pkg.
  - The package SHALL also hold the default MAX_LEVEL and TICK_BASE constants.
REQ-034 The speed divider SHALL be the sub-module level_tick_div, instantiated only under LEVEL_SPEED_TICK_EN.

Verification
REQ-035 Setup POINTS_PER_LEVEL=4, level_InBUS=0, 4 point pulses -> 4th edge gives load_OutLow=0 for 1 cycle, level_OutBUS=1, levelup_Out=1, counter=0.
REQ-036 point_In held high for 10 cycles -> exactly one point counted.
REQ-037 level_InBUS=3, 4 points -> no load strobe, FSM in MAXED; a further 8 points -> no response.
REQ-038 restart_InLow=0 in the same cycle as the 4th point -> clear_OutLow=0 for 1 cycle, no load strobe, counter=0.
REQ-039 Point arriving in the LOAD cycle -> counter=1 after WAIT.
REQ-040 LEVEL_SPEED_TICK_EN defined, TICK_BASE=16, level 0 then level 2 -> tick periods 16 then 4 clocks; reset asserted mid-LOAD -> load_OutLow=1 immediately.
